// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_ROL  = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_LOAD = 3'd5
  } usr_mode_t;

endpackage

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate/load with serial-word framing pulse.
// Optional registered parity output enabled by defining USR_PARITY_EN.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             word_valid
`ifdef USR_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             wv_next;
  logic             shifting;

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  always_comb begin
    q_next   = q;
    cnt_next = cnt;
    wv_next  = 1'b0;
    shifting = 1'b0;
    if (clr) begin
      q_next   = '0;
      cnt_next = '0;
    end else if (en) begin
      case (usr_mode_t'(mode))
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], sin};
          shifting = 1'b1;
        end
        MODE_SHR: begin
          q_next   = {sin, q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        MODE_LOAD: begin
          q_next   = pin;
          cnt_next = '0;
        end
        default:   q_next = q;
      endcase
      // Explicit wrap keeps framing correct for non-power-of-two widths.
      if (shifting) begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          wv_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q          <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      q          <= q_next;
      cnt        <= cnt_next;
      word_valid <= wv_next;
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_o <= 1'b0;
    else        parity_o <= ^q_next;
  end
`endif

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits, legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port clr  input  1  synchronous clear.
REQ-005 The block SHALL have port en  input  1  operation enable.
REQ-006 The block SHALL have port mode  input  3  operation select, usr_mode_t.
REQ-007 The block SHALL have port sin  input  1  serial data in.
REQ-008 The block SHALL have port pin  input  WIDTH  parallel load data.
REQ-009 The block SHALL have port q  output  WIDTH  register contents.
REQ-010 The block SHALL have port sout_l  output  1  equal to q[WIDTH-1], combinational.
REQ-011 The block SHALL have port sout_r  output  1  equal to q[0], combinational.
REQ-012 The block SHALL have port word_valid  output  1  one-cycle pulse, WIDTH serial bits accumulated.

Function
REQ-013 Modes SHALL be HOLD=0, SHL=1, SHR=2, ROL=3, ROR=4, LOAD=5; codes 6..7 SHALL behave as HOLD.
REQ-014 On each rising edge with en=1 and clr=0, q SHALL update per mode: SHL {q[W-2:0],sin}; SHR {sin,q[W-1:1]}; ROL {q[W-2:0],q[W-1]}; ROR {q[0],q[W-1:1]}; LOAD pin; HOLD unchanged.
REQ-015 With en=0 and clr=0, q, the shift counter and mode SHALL have no effect; q holds and word_valid SHALL be 0 next cycle.
REQ-016 clr=1 SHALL override en and mode: next edge q=0, counter=0, word_valid=0.
REQ-017 An internal counter cnt, width $clog2(WIDTH), SHALL increment on each enabled SHL or SHR only.
REQ-018 On an enabled SHL/SHR with cnt=WIDTH-1, cnt SHALL wrap to 0 and word_valid SHALL be 1 in the following cycle, coincident with q holding the completed word.
REQ-019 word_valid SHALL be 0 on every cycle not covered by REQ-018.
REQ-020 LOAD SHALL reset cnt to 0; ROL, ROR, HOLD SHALL leave cnt unchanged.
REQ-021 Mixing SHL and SHR within one word SHALL still count toward the same WIDTH-bit boundary.
REQ-022 Back-to-back words SHALL produce word_valid every WIDTH enabled shifts with no idle cycle required.

Reset
REQ-023 reset=0 SHALL asynchronously force q=0, cnt=0, word_valid=0, parity_o=0; deassertion SHALL be synchronised externally.
REQ-024 Reset mid-word SHALL discard partial bits; the next word SHALL require a full WIDTH shifts.

Configuration
REQ-025 With USR_PARITY_EN defined, the block SHALL add output parity_o (1 bit), registered, equal to XOR-reduction of the next q value, updated on the same edge as q.
REQ-026 Without USR_PARITY_EN, parity_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package usr_pkg SHALL hold typedef enum logic [2:0] usr_mode_t and the mode constants.
REQ-028 The shift/rotate datapath and control SHALL be flat in one module; no sub-module is required.

Verification
REQ-029 WIDTH=8: reset, SHL with sin=1,0,1,1,0,0,1,0 over 8 cycles -> q=8'hB2, word_valid=1 exactly in cycle after 8th shift.
REQ-030 LOAD pin=8'h81, then ROL x1 -> q=8'h03; ROR x2 -> q=8'hC0; word_valid never asserted.
REQ-031 Shift 5 bits, LOAD 8'h00, shift 8 bits -> word_valid only after the 8 post-load shifts.
REQ-032 16 consecutive SHL cycles with en=1 -> word_valid pulses after shift 8 and shift 16, low otherwise.
REQ-033 Shift 3 bits, assert clr with mode=LOAD, pin=8'hFF -> q=0, cnt restarts; async reset low mid-shift -> q=0 immediately without clock.
REQ-034 With USR_PARITY_EN: LOAD 8'h07 -> parity_o=1; SHL sin=0 -> q=8'h0E, parity_o=1; en=0 toggling sin -> q and parity_o unchanged.
